// File: rtl/tl_c_channel_arbiter.sv
// TileLink channel C arbiter: merges probe-unit and writeback-unit beats onto one
// C port, arbitrating per message and locking the port for multi-beat bursts.
//
// Ports:
//   clock, reset_n          single clock, synchronous active-low reset
//   prb_valid/ready/bits    ProbeAck / ProbeAckData beats from the probe unit
//   rel_valid/ready/bits    Release / ReleaseData beats from the writeback unit
//   c_valid/ready/bits      outgoing C beat toward the L2
//   c_first, c_last         beat position within the current message
//   busy, owner             burst in progress and its source (0 = probe, 1 = release)
//   size_err                one-cycle pulse after a first beat with an oversized lgSize

package BundleST;
  typedef struct packed {
    logic [2:0]   opcode;
    logic [2:0]   param;
    logic [3:0]   size;
    logic [3:0]   source;
    logic [31:0]  address;
    logic [127:0] data;
    logic         corrupt;
  } TLBundleCST;
endpackage

module tl_c_channel_arbiter
  import BundleST::*;
#(
  parameter int BEAT_BYTES = 16,
  parameter int MAX_LGSIZE = 6,
  parameter int PROBE_PRIO = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       prb_valid,
  output logic       prb_ready,
  input  TLBundleCST prb_bits,
  input  logic       rel_valid,
  output logic       rel_ready,
  input  TLBundleCST rel_bits,
  output logic       c_valid,
  input  logic       c_ready,
  output TLBundleCST c_bits,
  output logic       c_first,
  output logic       c_last,
  output logic       busy,
  output logic       owner,
  output logic       size_err
);

  localparam int LGB = $clog2(BEAT_BYTES);
  localparam int MAXBEATS = (1 << MAX_LGSIZE) / BEAT_BYTES;
  localparam int CW = $clog2(MAXBEATS) + 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } arbStateT;

  arbStateT state;
  arbStateT stateNext;

  logic [CW-1:0] remain;
  logic [CW-1:0] remainNext;
  logic [CW-1:0] beats;
  logic [3:0]    effSize;

  logic busyNext;
  logic ownerNext;
  logic sizeErrNext;
  logic rrLast;
  logic rrLastNext;
  logic held;
  logic heldNext;
  logic heldSel;
  logic heldSelNext;

  logic grant;
  logic fire;
  logic hasData;
  logic sizeOver;
  logic locked;
  logic bothValid;
  logic rrPick;

  assign locked = (state == LOCKED);
  assign bothValid = prb_valid && rel_valid;

  // rrLast remembers the last completed owner; the other one wins a tie.
  assign rrPick = (PROBE_PRIO != 0) ? 1'b0 : !rrLast;

  // A first beat offered under backpressure keeps its grant until it fires.
  always_comb begin
    grant = 1'b0;
    unique case (1'b1)
      locked:                      grant = owner;
      !locked && held:             grant = heldSel;
      !locked && !held && bothValid: grant = rrPick;
      default:                     grant = rel_valid;
    endcase
  end

  always_comb begin
    c_valid   = grant ? rel_valid : prb_valid;
    c_bits    = grant ? rel_bits : prb_bits;
    prb_ready = !grant && c_ready;
    rel_ready = grant && c_ready;
    fire      = c_valid && c_ready;
  end

  always_comb begin
    hasData  = c_bits.opcode[0];
    sizeOver = c_bits.size > 4'(MAX_LGSIZE);
    effSize  = sizeOver ? 4'(MAX_LGSIZE) : c_bits.size;
    beats    = CW'(1);
    if (hasData && (effSize > 4'(LGB))) begin
      beats = CW'(1) << (effSize - 4'(LGB));
    end
  end

  assign c_first = !locked;
  assign c_last  = locked ? (remain == CW'(1)) : (beats == CW'(1));

  always_comb begin
    stateNext   = state;
    remainNext  = remain;
    busyNext    = busy;
    ownerNext   = owner;
    rrLastNext  = rrLast;
    sizeErrNext = 1'b0;
    heldNext    = 1'b0;
    heldSelNext = heldSel;
    unique case (state)
      IDLE: begin
        if (fire) begin
          sizeErrNext = sizeOver;
          if (beats > CW'(1)) begin
            stateNext  = LOCKED;
            ownerNext  = grant;
            remainNext = beats - CW'(1);
            busyNext   = 1'b1;
          end else begin
            rrLastNext = grant;
          end
        end else if (c_valid) begin
          heldNext    = 1'b1;
          heldSelNext = grant;
        end
      end
      LOCKED: begin
        if (fire) begin
          remainNext = remain - CW'(1);
          if (remain == CW'(1)) begin
            stateNext  = IDLE;
            busyNext   = 1'b0;
            rrLastNext = owner;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state    <= IDLE;
      remain   <= '0;
      busy     <= 1'b0;
      owner    <= 1'b0;
      size_err <= 1'b0;
      rrLast   <= 1'b1;
      held     <= 1'b0;
      heldSel  <= 1'b0;
    end else begin
      state    <= stateNext;
      remain   <= remainNext;
      busy     <= busyNext;
      owner    <= ownerNext;
      size_err <= sizeErrNext;
      rrLast   <= rrLastNext;
      held     <= heldNext;
      heldSel  <= heldSelNext;
    end
  end

endmodule

// File: tb/tb_tl_c_channel_arbiter.sv
// Directed bench for tl_c_channel_arbiter: source queues feed both ports and
// a scoreboard of expected C beats is checked on every outgoing fire.

module tb_tl_c_channel_arbiter;
  import BundleST::*;

  localparam int LGB = 4;
  localparam int MAXLG = 6;

  typedef struct packed {
    logic         src;
    logic         first;
    logic         last;
    logic [127:0] data;
  } expT;

  logic clock = 1'b0;
  logic resetN;
  logic prbValid;
  logic relValid;
  logic cReady;
  TLBundleCST prbBits;
  TLBundleCST relBits;

  logic prbReady0, relReady0, cValid0, cFirst0, cLast0;
  logic busy0, owner0, sizeErr0;
  TLBundleCST cBits0;
  logic prbReady1, relReady1, cValid1, cFirst1, cLast1;
  logic busy1, owner1, sizeErr1;
  TLBundleCST cBits1;

  int compared = 0;
  int mismatched = 0;
  int fireCnt = 0;

  TLBundleCST prbQ[$];
  TLBundleCST relQ[$];
  expT expQ[$];

  logic prbOn, relOn, useAlt;
  logic obsValid, obsPrbReady, obsRelReady, obsFirst;
  logic obsBusy, obsOwner, obsSizeErr;
  TLBundleCST obsBits;
  logic [6:0] pat = 7'b1011001;

  always #5 clock = ~clock;

  tl_c_channel_arbiter #(
    .BEAT_BYTES(16), .MAX_LGSIZE(6), .PROBE_PRIO(1)
  ) dut0 (
    .clock(clock), .reset_n(resetN),
    .prb_valid(prbValid), .prb_ready(prbReady0), .prb_bits(prbBits),
    .rel_valid(relValid), .rel_ready(relReady0), .rel_bits(relBits),
    .c_valid(cValid0), .c_ready(cReady), .c_bits(cBits0),
    .c_first(cFirst0), .c_last(cLast0),
    .busy(busy0), .owner(owner0), .size_err(sizeErr0)
  );

  tl_c_channel_arbiter #(
    .BEAT_BYTES(16), .MAX_LGSIZE(6), .PROBE_PRIO(0)
  ) dut1 (
    .clock(clock), .reset_n(resetN),
    .prb_valid(prbValid), .prb_ready(prbReady1), .prb_bits(prbBits),
    .rel_valid(relValid), .rel_ready(relReady1), .rel_bits(relBits),
    .c_valid(cValid1), .c_ready(cReady), .c_bits(cBits1),
    .c_first(cFirst1), .c_last(cLast1),
    .busy(busy1), .owner(owner1), .size_err(sizeErr1)
  );

  task automatic chkBit(input string tag, input logic obs, input logic exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic chkWord(input string tag, input logic [127:0] obs,
                         input logic [127:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkInt(input string tag, input int obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int expBeats(input logic [2:0] op, input logic [3:0] size);
    int s;
    s = (size > 4'(MAXLG)) ? MAXLG : int'(size);
    if (!op[0] || s <= LGB) return 1;
    return 1 << (s - LGB);
  endfunction

  task automatic sendMsg(input logic src, input logic [2:0] op,
                         input logic [3:0] size, input logic [7:0] tag);
    int n;
    TLBundleCST b;
    expT e;
    n = expBeats(op, size);
    for (int i = 0; i < n; i++) begin
      b = '0;
      b.opcode = op;
      b.size = size;
      b.source = {3'b000, src};
      b.address = 32'h0000_1000;
      b.data[15:0] = {tag, 8'(i)};
      b.data[127:96] = $urandom();
      if (src) relQ.push_back(b);
      else prbQ.push_back(b);
      e.src = src;
      e.first = (i == 0);
      e.last = (i == n - 1);
      e.data = b.data;
      expQ.push_back(e);
    end
  endtask

  task automatic tick();
    logic pr, rr, pf, rf, lst;
    expT e;
    prbValid = prbOn && (prbQ.size() > 0);
    if (prbQ.size() > 0) prbBits = prbQ[0];
    else prbBits = '0;
    relValid = relOn && (relQ.size() > 0);
    if (relQ.size() > 0) relBits = relQ[0];
    else relBits = '0;
    #2;
    pr = useAlt ? prbReady1 : prbReady0;
    rr = useAlt ? relReady1 : relReady0;
    obsValid = useAlt ? cValid1 : cValid0;
    obsBits = useAlt ? cBits1 : cBits0;
    obsFirst = useAlt ? cFirst1 : cFirst0;
    lst = useAlt ? cLast1 : cLast0;
    obsBusy = useAlt ? busy1 : busy0;
    obsOwner = useAlt ? owner1 : owner0;
    obsSizeErr = useAlt ? sizeErr1 : sizeErr0;
    obsPrbReady = pr;
    obsRelReady = rr;
    pf = prbValid && pr;
    rf = relValid && rr;
    if (obsValid && cReady) begin
      fireCnt++;
      chkBit("one_source_fires", pf ^ rf, 1'b1);
      chkInt("beat_expected", (expQ.size() > 0) ? 1 : 0, 1);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chkBit("beat_src", rf, e.src);
        chkWord("beat_data", obsBits.data, e.data);
        chkBit("beat_first", obsFirst, e.first);
        chkBit("beat_last", lst, e.last);
      end
    end
    @(negedge clock);
    if (pf) void'(prbQ.pop_front());
    if (rf) void'(relQ.pop_front());
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget && expQ.size() > 0; i++) tick();
    chkInt(tag, expQ.size(), 0);
    expQ.delete();
    prbQ.delete();
    relQ.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int f0;
    int errCnt;
    resetN = 1'b0;
    prbValid = 1'b0;
    relValid = 1'b0;
    cReady = 1'b0;
    prbBits = '0;
    relBits = '0;
    prbOn = 1'b0;
    relOn = 1'b0;
    useAlt = 1'b0;
    @(negedge clock);
    tick();
    tick();
    resetN = 1'b1;
    tick();
    chkBit("rst_c_valid", obsValid, 1'b0);
    chkBit("rst_busy", obsBusy, 1'b0);
    chkBit("rst_owner", obsOwner, 1'b0);
    chkBit("rst_size_err", obsSizeErr, 1'b0);
    chkBit("rst_c_first", obsFirst, 1'b1);
    chkBit("rst_c_valid_rr", cValid1, 1'b0);

    // single dataless ProbeAck
    cReady = 1'b1;
    prbOn = 1'b1;
    relOn = 1'b1;
    f0 = fireCnt;
    sendMsg(1'b0, 3'd4, 4'd6, 8'h11);
    tick();
    chkInt("t1_latency", fireCnt - f0, 1);
    tick();
    chkBit("t1_busy", obsBusy, 1'b0);
    drain("t1_drain", 2);

    // release burst locks out a later probe
    prbOn = 1'b0;
    f0 = fireCnt;
    sendMsg(1'b1, 3'd7, 4'd6, 8'h21);
    tick();
    prbOn = 1'b1;
    sendMsg(1'b0, 3'd4, 4'd6, 8'h22);
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i < 4) chkBit("t2_prb_ready_locked", obsPrbReady, 1'b0);
      if (i == 1) begin
        chkBit("t2_busy", obsBusy, 1'b1);
        chkBit("t2_owner", obsOwner, 1'b1);
      end
    end
    chkBit("t2_prb_ready_after", obsPrbReady, 1'b1);
    chkInt("t2_fires", fireCnt - f0, 5);
    drain("t2_drain", 4);

    // fixed priority tie
    sendMsg(1'b0, 3'd4, 4'd6, 8'h31);
    sendMsg(1'b1, 3'd6, 4'd6, 8'h32);
    tick();
    chkBit("t3_rel_ready", obsRelReady, 1'b0);
    chkBit("t3_prb_ready", obsPrbReady, 1'b1);
    drain("t3_drain", 4);

    // stalled first beat keeps its grant
    cReady = 1'b0;
    prbOn = 1'b0;
    sendMsg(1'b1, 3'd6, 4'd6, 8'h35);
    tick();
    prbOn = 1'b1;
    sendMsg(1'b0, 3'd4, 4'd6, 8'h36);
    tick();
    chkWord("t3c_hold_bits", obsBits.data, expQ[0].data);
    cReady = 1'b1;
    drain("t3c_drain", 4);

    // round-robin on the PROBE_PRIO=0 instance
    resetN = 1'b0;
    tick();
    resetN = 1'b1;
    useAlt = 1'b1;
    f0 = fireCnt;
    sendMsg(1'b0, 3'd4, 4'd6, 8'h41);
    sendMsg(1'b1, 3'd6, 4'd6, 8'h42);
    sendMsg(1'b0, 3'd4, 4'd6, 8'h43);
    sendMsg(1'b1, 3'd6, 4'd6, 8'h44);
    for (int i = 0; i < 4; i++) tick();
    chkInt("t3b_fires", fireCnt - f0, 4);
    drain("t3b_drain", 4);
    useAlt = 1'b0;

    // backpressure on a ProbeAckData burst
    relOn = 1'b0;
    f0 = fireCnt;
    sendMsg(1'b0, 3'd5, 4'd6, 8'h51);
    for (int i = 0; i < 7; i++) begin
      cReady = pat[i];
      tick();
      if (!pat[i]) begin
        chkBit("t4_stall_valid", obsValid, 1'b1);
        if (expQ.size() > 0)
          chkWord("t4_stall_bits", obsBits.data, expQ[0].data);
      end
      if (i == 1 || i == 6) chkBit("t4_busy_mid", obsBusy, 1'b1);
    end
    chkInt("t4_fires", fireCnt - f0, 4);
    cReady = 1'b0;
    tick();
    chkBit("t4_busy_end", obsBusy, 1'b0);
    drain("t4_drain", 2);

    // oversized ReleaseData is clamped
    cReady = 1'b1;
    relOn = 1'b1;
    errCnt = 0;
    f0 = fireCnt;
    sendMsg(1'b1, 3'd7, 4'd7, 8'h61);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (obsSizeErr) errCnt++;
      if (i == 1) chkBit("t5_err_timing", obsSizeErr, 1'b1);
    end
    chkInt("t5_err_count", errCnt, 1);
    chkInt("t5_fires", fireCnt - f0, 4);
    drain("t5_drain", 2);

    // reset abandons a burst
    sendMsg(1'b1, 3'd7, 4'd6, 8'h71);
    tick();
    tick();
    chkBit("t6_busy_mid", obsBusy, 1'b1);
    resetN = 1'b0;
    cReady = 1'b0;
    relOn = 1'b0;
    tick();
    resetN = 1'b1;
    relQ.delete();
    expQ.delete();
    tick();
    chkBit("t6_busy_rst", obsBusy, 1'b0);
    chkBit("t6_idle", obsFirst, 1'b1);
    chkBit("t6_valid", obsValid, 1'b0);
    relOn = 1'b1;
    cReady = 1'b1;
    f0 = fireCnt;
    sendMsg(1'b1, 3'd7, 4'd6, 8'h72);
    drain("t6_drain", 8);
    chkInt("t6_fires", fireCnt - f0, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
